// File: rtl/dsp_pipe_pkg.sv
// Shared types and constants for the ID->EX issue/hazard control path.
package dsp_pipe_pkg;
    localparam int TAG_W       = 5;
    localparam int NUM_REGS    = 32;
    localparam int CNT_W       = 3;
    localparam int NUM_SRC     = 9;
    localparam int NUM_SLOT    = 4;
    localparam int MUL_LAT_DEF = 3;
    localparam int LD_LAT_DEF  = 2;

    // Slot indices double as bit positions in the cnd vector and the dest tag bus.
    localparam int SLOT_A0 = 3;
    localparam int SLOT_A1 = 2;
    localparam int SLOT_M  = 1;
    localparam int SLOT_LS = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        MEM   = 2'd2,
        FLUSH = 2'd3
    } hz_state_e;

    function automatic logic [TAG_W-1:0] slot_tag(input logic [NUM_SLOT*TAG_W-1:0] tags,
                                                  input int slot);
        return tags[slot*TAG_W +: TAG_W];
    endfunction
endpackage

// File: rtl/scoreboard_ctr.sv
// Per-register down-counters tracking in-flight MUL/LOAD results; r0 is never tracked.
module scoreboard_ctr
    import dsp_pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int LD_LAT  = LD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze_i,
    input  logic                set_m_i,
    input  logic [TAG_W-1:0]    set_m_tag_i,
    input  logic                set_ld_i,
    input  logic [TAG_W-1:0]    set_ld_tag_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);
    localparam logic [CNT_W-1:0] M_INIT  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LD_LAT - 1);

    logic [NUM_REGS-1:1][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (!freeze_i && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
            // A new set overrides the decrement; M is applied last so it wins a collision.
            if (set_ld_i && set_ld_tag_i == TAG_W'(r))
                cnt_d[r] = LD_INIT;
            if (set_m_i && set_m_tag_i == TAG_W'(r))
                cnt_d[r] = M_INIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        busy_vec_o    = '0;
        for (int r = 1; r < NUM_REGS; r++)
            busy_vec_o[r] = |cnt_q[r];
    end
endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue/hazard sequencer for the A0/A1/M/LS bundle: hazard detection, memory stall,
// mispredict flush sequencing, and scoreboard updates on issue.
module issue_hazard_ctrl
    import dsp_pipe_pkg::*;
#(
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int LD_LAT    = LD_LAT_DEF,
    parameter int FLUSH_CYC = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [NUM_SRC*TAG_W-1:0]    id_src_tags,
    input  logic [NUM_SLOT*TAG_W-1:0]   id_dst_tags,
    input  logic [NUM_SLOT-1:0]         id_cnd,
    input  logic                        id_m_en,
    input  logic                        id_ld_en,
    input  logic                        id_st_en,
    input  logic                        ex_mem_op,
    input  logic                        mem_ready,
    input  logic                        br_mispredict,
    output logic                        stall,
    output logic                        flush,
    output logic                        issue,
    output logic [NUM_REGS-1:0]         busy_vec,
    output logic [1:0]                  state
);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    hz_state_e       state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             mem_stall, hz_src, hz_waw, hazard, pend_eff;
    logic [TAG_W-1:0] m_rd, ls_rd;

    assign m_rd  = slot_tag(id_dst_tags, SLOT_M);
    assign ls_rd = slot_tag(id_dst_tags, SLOT_LS);

    always_comb begin
        hz_src = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (id_src_tags[i*TAG_W +: TAG_W] != '0 && busy_vec[id_src_tags[i*TAG_W +: TAG_W]])
                hz_src = 1'b1;
    end

    // Stores never write lsRd, so that tag is not a WAW candidate for them.
    always_comb begin
        hz_waw = 1'b0;
        for (int s = 0; s < NUM_SLOT; s++)
            if (slot_tag(id_dst_tags, s) != '0 && !id_cnd[s] && !(s == SLOT_LS && id_st_en)
                && busy_vec[slot_tag(id_dst_tags, s)])
                hz_waw = 1'b1;
    end

    assign hazard    = hz_src | hz_waw;
    assign mem_stall = ex_mem_op & ~mem_ready;
    assign flush     = (state_q == FLUSH);
    assign stall     = ~rst & (mem_stall | (id_valid & hazard & ~flush));
    assign issue     = ~rst & id_valid & ~stall & ~flush;
    assign state     = state_q;

    scoreboard_ctr #(
        .MUL_LAT (MUL_LAT),
        .LD_LAT  (LD_LAT)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .freeze_i     (mem_stall),
        .set_m_i      (issue & id_m_en & ~id_cnd[SLOT_M] & (m_rd != '0)),
        .set_m_tag_i  (m_rd),
        .set_ld_i     (issue & id_ld_en & ~id_cnd[SLOT_LS] & (ls_rd != '0)),
        .set_ld_tag_i (ls_rd),
        .busy_vec_o   (busy_vec)
    );

    // A mispredict arriving under a memory stall parks in flush_pend until EX unfreezes;
    // one arriving during FLUSH restarts the flush window immediately.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pend_eff     = flush_pend_q | br_mispredict;
        flush_pend_d = pend_eff;
        if (pend_eff && (flush || !mem_stall)) begin
            state_d      = FLUSH;
            flush_cnt_d  = FC_W'(FLUSH_CYC - 1);
            flush_pend_d = 1'b0;
        end else if (flush && flush_cnt_q != '0) begin
            state_d     = FLUSH;
            flush_cnt_d = flush_cnt_q - 1'b1;
        end else if (mem_stall) begin
            state_d = MEM;
        end else if (id_valid && hazard) begin
            state_d = HAZ;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Cycle-table bench for issue_hazard_ctrl with a queue of expected per-cycle outputs.
module tb_issue_hazard_ctrl;
    import dsp_pipe_pkg::*;

    logic        clk, rst;
    logic        id_valid, id_m_en, id_ld_en, id_st_en;
    logic [44:0] id_src_tags;
    logic [19:0] id_dst_tags;
    logic [3:0]  id_cnd;
    logic        ex_mem_op, mem_ready, br_mispredict;
    logic        stall, flush, issue;
    logic [31:0] busy_vec;
    logic [1:0]  state;

    issue_hazard_ctrl #(.MUL_LAT(3), .LD_LAT(2), .FLUSH_CYC(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_tags(id_src_tags),
        .id_dst_tags(id_dst_tags), .id_cnd(id_cnd), .id_m_en(id_m_en),
        .id_ld_en(id_ld_en), .id_st_en(id_st_en), .ex_mem_op(ex_mem_op),
        .mem_ready(mem_ready), .br_mispredict(br_mispredict), .stall(stall),
        .flush(flush), .issue(issue), .busy_vec(busy_vec), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int P_A0R0 = 8;
    localparam int P_LSR1 = 1;

    typedef struct {
        logic        v;
        logic [44:0] src;
        logic [19:0] dst;
        logic [3:0]  cnd;
        logic [2:0]  en;     // {m_en, ld_en, st_en}
        logic [2:0]  ctl;    // {ex_mem_op, mem_ready, br_mispredict}
        logic [2:0]  e_out;  // {stall, issue, flush}
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [44:0] src_at(input int pos, input int tag);
        logic [44:0] s;
        s = '0;
        s[pos*5 +: 5] = 5'(tag);
        return s;
    endfunction

    function automatic logic [19:0] dst_at(input int slot, input int tag);
        logic [19:0] d;
        d = '0;
        d[slot*5 +: 5] = 5'(tag);
        return d;
    endfunction

    function automatic void add(input logic v, input logic [44:0] src, input logic [19:0] dst,
                                input logic [3:0] cnd, input logic [2:0] en, input logic [2:0] ctl,
                                input logic [2:0] e_out, input logic [31:0] e_busy);
        vec_t r;
        r.v = v; r.src = src; r.dst = dst; r.cnd = cnd; r.en = en; r.ctl = ctl;
        r.e_out = e_out; r.e_busy = e_busy;
        tbl.push_back(r);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        id_valid = r.v; id_src_tags = r.src; id_dst_tags = r.dst; id_cnd = r.cnd;
        {id_m_en, id_ld_en, id_st_en} = r.en;
        {ex_mem_op, mem_ready, br_mispredict} = r.ctl;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_src_tags = '0; id_dst_tags = '0; id_cnd = '0;
        id_m_en = 0; id_ld_en = 0; id_st_en = 0;
        ex_mem_op = 0; mem_ready = 0; br_mispredict = 0;
    endtask

    initial begin
        vec_t e;
        // reset: combinational outputs must stay low even with stall-provoking inputs
        idle_inputs();
        rst = 1'b1;
        id_valid = 1; ex_mem_op = 1; mem_ready = 0;
        #12;
        check("rst_stall", 0, 32'(stall), 0);
        check("rst_issue", 0, 32'(issue), 0);
        check("rst_flush", 0, 32'(flush), 0);
        check("rst_busy",  0, busy_vec, 0);
        check("rst_state", 0, 32'(state), 32'(RUN));
        idle_inputs();
        #1 rst = 1'b0;

        // MUL r5 then reader: 2 stall cycles
        add(1, '0, dst_at(SLOT_M, 5), 4'b0000, 3'b100, 3'b000, 3'b010, 32'h0);
        add(1, src_at(P_A0R0, 5), '0, 4'b0000, 3'b000, 3'b000, 3'b100, 32'h20);
        add(1, src_at(P_A0R0, 5), '0, 4'b0000, 3'b000, 3'b000, 3'b100, 32'h20);
        add(1, src_at(P_A0R0, 5), '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        add(0, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b000, 32'h0);
        // LOAD r7 then lsR1 reader: 1 stall cycle
        add(1, '0, dst_at(SLOT_LS, 7), 4'b0000, 3'b010, 3'b000, 3'b010, 32'h0);
        add(1, src_at(P_LSR1, 7), '0, 4'b0000, 3'b000, 3'b000, 3'b100, 32'h80);
        add(1, src_at(P_LSR1, 7), '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        // cnd=1 on M write r9: not tracked
        add(1, '0, dst_at(SLOT_M, 9), 4'b0010, 3'b100, 3'b000, 3'b010, 32'h0);
        add(1, src_at(P_A0R0, 9), '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        // WAW on r3, then same dest with cnd=1 on A0
        add(1, '0, dst_at(SLOT_M, 3), 4'b0000, 3'b100, 3'b000, 3'b010, 32'h0);
        add(1, '0, dst_at(SLOT_A0, 3), 4'b0000, 3'b000, 3'b000, 3'b100, 32'h08);
        add(1, '0, dst_at(SLOT_A0, 3), 4'b1000, 3'b000, 3'b000, 3'b010, 32'h08);
        // store lsRd on busy r4 is ignored
        add(1, '0, dst_at(SLOT_M, 4), 4'b0000, 3'b100, 3'b000, 3'b010, 32'h0);
        add(1, '0, dst_at(SLOT_LS, 4), 4'b0000, 3'b001, 3'b000, 3'b010, 32'h10);
        add(0, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b000, 32'h10);
        add(0, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b000, 32'h0);
        // mem stall for 3 cycles freezes cnt[5]=2
        add(1, '0, dst_at(SLOT_M, 5), 4'b0000, 3'b100, 3'b000, 3'b010, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b100, 3'b100, 32'h20);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b100, 3'b100, 32'h20);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b100, 3'b100, 32'h20);
        add(1, src_at(P_A0R0, 5), '0, 4'b0000, 3'b000, 3'b000, 3'b100, 32'h20);
        add(1, src_at(P_A0R0, 5), '0, 4'b0000, 3'b000, 3'b000, 3'b100, 32'h20);
        add(1, src_at(P_A0R0, 5), '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        // mispredict in RUN
        add(1, '0, '0, 4'b0000, 3'b000, 3'b001, 3'b010, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b001, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        // mispredict under mem stall: flush the cycle after mem_ready
        add(1, '0, '0, 4'b0000, 3'b000, 3'b101, 3'b100, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b100, 3'b100, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b110, 3'b010, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b001, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        // hazard masked during flush; counts keep draining
        add(1, '0, dst_at(SLOT_M, 6), 4'b0000, 3'b100, 3'b000, 3'b010, 32'h0);
        add(1, src_at(P_A0R0, 6), '0, 4'b0000, 3'b000, 3'b001, 3'b100, 32'h40);
        add(1, src_at(P_A0R0, 6), '0, 4'b0000, 3'b000, 3'b000, 3'b001, 32'h40);
        add(1, src_at(P_A0R0, 6), '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);
        // mispredict during FLUSH restarts the window
        add(1, '0, '0, 4'b0000, 3'b000, 3'b001, 3'b010, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b001, 3'b001, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b001, 32'h0);
        add(1, '0, '0, 4'b0000, 3'b000, 3'b000, 3'b010, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check("stall", i, 32'(stall), 32'(e.e_out[2]));
            check("issue", i, 32'(issue), 32'(e.e_out[1]));
            check("flush", i, 32'(flush), 32'(e.e_out[0]));
            check("busy",  i, busy_vec, e.e_busy);
            if (e.e_out[0]) check("flush_state", i, 32'(state), 32'(FLUSH));
        end

        // async reset mid-stall with r5 and r7 in flight
        @(posedge clk); #1;
        idle_inputs();
        id_valid = 1; id_m_en = 1; id_ld_en = 1;
        id_dst_tags = dst_at(SLOT_M, 5) | dst_at(SLOT_LS, 7);
        @(negedge clk);
        check("pair_issue", 100, 32'(issue), 1);
        @(posedge clk); #1;
        idle_inputs();
        id_valid = 1; id_src_tags = src_at(P_A0R0, 5);
        @(negedge clk);
        check("pair_busy",  101, busy_vec, 32'h0000_00A0);
        check("pair_stall", 101, 32'(stall), 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_stall", 102, 32'(stall), 0);
        check("mid_rst_flush", 102, 32'(flush), 0);
        check("mid_rst_busy",  102, busy_vec, 0);
        check("mid_rst_state", 102, 32'(state), 32'(RUN));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 103, 32'(stall), 0);
        check("post_rst_issue", 103, 32'(issue), 1);

        if (exp_q.size() != 0) check("queue_drain", 104, 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
